// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane count.
// LSU_MISALIGN_CHECK_EN adds the FAULT state used for misaligned accesses.
package lsu_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    ST_FAULT = 2'd3
`endif
  } state_t;

  // Size 3 is reserved and behaves as a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, memory-port and completion signals of the load/store unit.
// slave = the LSU's view, master = the surrounding pipeline/memory view.
interface load_store_unit_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_addr;
  logic [WIDTH-1:0] i_wdata;
  logic             i_store;
  logic [1:0]       i_size;
  logic             i_unsigned;
  logic [4:0]       i_rd;

  logic             o_mem_req;
  logic             o_mem_we;
  logic [WIDTH-1:0] o_mem_addr;
  logic [WIDTH-1:0] o_mem_wdata;
  logic [3:0]       o_mem_wstrb;
  logic             i_mem_gnt;
  logic             i_mem_rvalid;
  logic [WIDTH-1:0] i_mem_rdata;

  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic [4:0]       o_rd;
  logic             o_fault;

  modport slave (
    input  i_valid, i_addr, i_wdata, i_store, i_size, i_unsigned, i_rd,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    output o_done, o_result, o_rd, o_fault
  );

  modport master (
    output i_valid, i_addr, i_wdata, i_store, i_size, i_unsigned, i_rd,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    input  o_done, o_result, o_rd, o_fault
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store strobe/replication on the request side,
// load shift and sign/zero extension on the response side.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       st_lo,
  input  logic [1:0]       st_size,
  input  logic [WIDTH-1:0] st_data,
  output logic [LANES-1:0] st_strb,
  output logic [WIDTH-1:0] st_wdata,
  input  logic [1:0]       ld_lo,
  input  logic [1:0]       ld_size,
  input  logic             ld_unsigned,
  input  logic [WIDTH-1:0] ld_rdata,
  output logic [WIDTH-1:0] ld_data
);

  logic [4:0]       shamt;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    st_strb  = '1;
    st_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_strb  = 4'b0001 << st_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_strb  = 4'b0011 << {st_lo[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_size)
      SZ_BYTE: shamt = {ld_lo, 3'b000};
      SZ_HALF: shamt = {ld_lo[1], 4'b0000};
      default: shamt = '0;
    endcase
    shifted = ld_rdata >> shamt;
    case (ld_size)
      SZ_BYTE: ld_data = ld_unsigned ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      SZ_HALF: ld_data = ld_unsigned ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit on a valid/grant/response memory port.
// Optional misaligned-access fault path: define LSU_MISALIGN_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              i_clk,
  input logic              i_rst,
  load_store_unit_if.slave bus
);

  state_t           state;
  logic [1:0]       lo_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             store_q;
  logic [4:0]       rd_q;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       rd;

  logic [3:0]       st_strb;
  logic [WIDTH-1:0] st_wdata;
  logic [WIDTH-1:0] ld_data;
  logic             finish;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .st_lo       (bus.i_addr[1:0]),
    .st_size     (bus.i_size),
    .st_data     (bus.i_wdata),
    .st_strb     (st_strb),
    .st_wdata    (st_wdata),
    .ld_lo       (lo_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_rdata    (bus.i_mem_rdata),
    .ld_data     (ld_data)
  );

  assign finish = bus.i_mem_rvalid &&
                  ((state == ST_REQ && bus.i_mem_gnt) || state == ST_WAIT);

`ifdef LSU_MISALIGN_CHECK_EN
  logic fault;
  assign bus.o_fault = fault;
`else
  assign bus.o_fault = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      lo_q      <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      store_q   <= 1'b0;
      rd_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      done      <= 1'b0;
      result    <= '0;
      rd        <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      fault     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_valid) begin
            lo_q    <= bus.i_addr[1:0];
            size_q  <= bus.i_size;
            uns_q   <= bus.i_unsigned;
            store_q <= bus.i_store;
            rd_q    <= bus.i_rd;
`ifdef LSU_MISALIGN_CHECK_EN
            if (misaligned(bus.i_size, bus.i_addr[1:0])) begin
              state  <= ST_FAULT;
              done   <= 1'b1;
              fault  <= 1'b1;
              result <= '0;
              rd     <= bus.i_rd;
            end else
`endif
            begin
              state     <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= bus.i_store;
              mem_addr  <= {bus.i_addr[WIDTH-1:2], 2'b00};
              mem_wdata <= st_wdata;
              mem_wstrb <= bus.i_store ? st_strb : 4'b0000;
            end
          end
        end
        ST_REQ: begin
          if (bus.i_mem_gnt) begin
            mem_req <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: ;
        default: state <= ST_IDLE;
      endcase

      // Same-cycle grant+response in REQ completes here, overriding the WAIT move.
      if (finish) begin
        state  <= ST_IDLE;
        done   <= 1'b1;
        result <= store_q ? '0 : ld_data;
        rd     <= rd_q;
`ifdef LSU_MISALIGN_CHECK_EN
        fault  <= 1'b0;
`endif
      end
    end
  end

  assign bus.o_ready     = (state == ST_IDLE);
  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_wstrb = mem_wstrb;
  assign bus.o_done      = done;
  assign bus.o_result    = result;
  assign bus.o_rd        = rd;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.WIDTH(32)) bus ();

  load_store_unit #(.WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata, input logic store,
                           input logic [1:0] size, input logic uns, input logic [4:0] rd);
    bus.i_valid    = 1'b1;
    bus.i_addr     = addr;
    bus.i_wdata    = wdata;
    bus.i_store    = store;
    bus.i_size     = size;
    bus.i_unsigned = uns;
    bus.i_rd       = rd;
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, ".ready"}, {31'd0, bus.o_ready}, 32'd1);
    check({tag, ".req"},   {31'd0, bus.o_mem_req}, 32'd0);
    check({tag, ".we"},    {31'd0, bus.o_mem_we}, 32'd0);
    check({tag, ".wstrb"}, {28'd0, bus.o_mem_wstrb}, 32'd0);
    check({tag, ".addr"},  bus.o_mem_addr, 32'd0);
    check({tag, ".wdata"}, bus.o_mem_wdata, 32'd0);
    check({tag, ".done"},  {31'd0, bus.o_done}, 32'd0);
    check({tag, ".result"}, bus.o_result, 32'd0);
    check({tag, ".rd"},    {27'd0, bus.o_rd}, 32'd0);
    check({tag, ".fault"}, {31'd0, bus.o_fault}, 32'd0);
  endtask

  initial begin
    bus.i_valid      = 1'b0;
    bus.i_addr       = '0;
    bus.i_wdata      = '0;
    bus.i_store      = 1'b0;
    bus.i_size       = 2'd0;
    bus.i_unsigned   = 1'b0;
    bus.i_rd         = '0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    reset_outputs_check("reset");

    // Word load 0x1000: gnt at cycle 1, rvalid at cycle 3, done at cycle 4
    drive_req(32'h0000_1000, 32'h0, 1'b0, 2'd2, 1'b0, 5'd5);
    tick();
    bus.i_valid = 1'b0;
    check("wl.req", {31'd0, bus.o_mem_req}, 32'd1);
    check("wl.ready", {31'd0, bus.o_ready}, 32'd0);
    check("wl.addr", bus.o_mem_addr, 32'h0000_1000);
    check("wl.we", {31'd0, bus.o_mem_we}, 32'd0);
    check("wl.wstrb", {28'd0, bus.o_mem_wstrb}, 32'd0);
    bus.i_mem_gnt = 1'b1;
    tick();
    bus.i_mem_gnt = 1'b0;
    check("wl.req_drop", {31'd0, bus.o_mem_req}, 32'd0);
    tick();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hDEAD_BEEF;
    check("wl.done_early", {31'd0, bus.o_done}, 32'd0);
    tick();
    bus.i_mem_rvalid = 1'b0;
    check("wl.done", {31'd0, bus.o_done}, 32'd1);
    check("wl.ready_done", {31'd0, bus.o_ready}, 32'd1);
    check("wl.result", bus.o_result, 32'hDEAD_BEEF);
    check("wl.rd", {27'd0, bus.o_rd}, 32'd5);
    check("wl.fault", {31'd0, bus.o_fault}, 32'd0);
    tick();
    check("wl.done_pulse", {31'd0, bus.o_done}, 32'd0);
    check("wl.result_hold", bus.o_result, 32'hDEAD_BEEF);

    // Signed byte load at 0x1003, minimum latency
    drive_req(32'h0000_1003, 32'h0, 1'b0, 2'd0, 1'b0, 5'd3);
    tick();
    bus.i_valid      = 1'b0;
    bus.i_mem_gnt    = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h80FF_FFFF;
    tick();
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    check("sb.done", {31'd0, bus.o_done}, 32'd1);
    check("sb.result", bus.o_result, 32'hFFFF_FF80);
    check("sb.rd", {27'd0, bus.o_rd}, 32'd3);
    check("sb.ready", {31'd0, bus.o_ready}, 32'd1);

    // Back-to-back: unsigned byte load accepted in the done cycle
    drive_req(32'h0000_1003, 32'h0, 1'b0, 2'd0, 1'b1, 5'd4);
    tick();
    bus.i_valid = 1'b0;
    check("ub.req", {31'd0, bus.o_mem_req}, 32'd1);
    bus.i_mem_gnt    = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h80FF_FFFF;
    tick();
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    check("ub.done", {31'd0, bus.o_done}, 32'd1);
    check("ub.result", bus.o_result, 32'h0000_0080);

    // Signed half load from the upper half
    drive_req(32'h0000_2002, 32'h0, 1'b0, 2'd1, 1'b0, 5'd6);
    tick();
    bus.i_valid      = 1'b0;
    bus.i_mem_gnt    = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h8001_1234;
    tick();
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    check("sh.result", bus.o_result, 32'hFFFF_8001);

    // Byte store at lane 1
    drive_req(32'h0000_3001, 32'h1234_565A, 1'b1, 2'd0, 1'b0, 5'd2);
    tick();
    bus.i_valid = 1'b0;
    check("bs.wstrb", {28'd0, bus.o_mem_wstrb}, 32'h2);
    check("bs.wdata", bus.o_mem_wdata, 32'h5A5A_5A5A);
    check("bs.addr", bus.o_mem_addr, 32'h0000_3000);
    bus.i_mem_gnt    = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    tick();
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    check("bs.done", {31'd0, bus.o_done}, 32'd1);

    // Half store at 0x2002, grant withheld 5 cycles with a stray rvalid
    drive_req(32'h0000_2002, 32'h0000_ABCD, 1'b1, 2'd1, 1'b0, 5'd7);
    tick();
    bus.i_valid = 1'b0;
    check("hs.we", {31'd0, bus.o_mem_we}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hs.req_hold", {31'd0, bus.o_mem_req}, 32'd1);
      check("hs.addr_hold", bus.o_mem_addr, 32'h0000_2000);
      check("hs.wdata_hold", bus.o_mem_wdata, 32'hABCD_ABCD);
      check("hs.wstrb_hold", {28'd0, bus.o_mem_wstrb}, 32'hC);
      check("hs.no_done", {31'd0, bus.o_done}, 32'd0);
      bus.i_mem_rvalid = (i == 2);
      tick();
    end
    bus.i_mem_rvalid = 1'b0;
    check("hs.stray_ignored", {31'd0, bus.o_done}, 32'd0);
    bus.i_mem_gnt = 1'b1;
    tick();
    bus.i_mem_gnt = 1'b0;
    check("hs.req_drop", {31'd0, bus.o_mem_req}, 32'd0);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hFFFF_FFFF;
    tick();
    bus.i_mem_rvalid = 1'b0;
    check("hs.done", {31'd0, bus.o_done}, 32'd1);
    check("hs.result", bus.o_result, 32'd0);
    check("hs.rd", {27'd0, bus.o_rd}, 32'd7);

    // Misaligned word load at 0x1002
    drive_req(32'h0000_1002, 32'h0, 1'b0, 2'd2, 1'b0, 5'd9);
    tick();
    bus.i_valid = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis.done", {31'd0, bus.o_done}, 32'd1);
    check("mis.fault", {31'd0, bus.o_fault}, 32'd1);
    check("mis.req", {31'd0, bus.o_mem_req}, 32'd0);
    check("mis.result", bus.o_result, 32'd0);
    check("mis.rd", {27'd0, bus.o_rd}, 32'd9);
    tick();
    check("mis.ready", {31'd0, bus.o_ready}, 32'd1);
    check("mis.req_after", {31'd0, bus.o_mem_req}, 32'd0);
    check("mis.done_pulse", {31'd0, bus.o_done}, 32'd0);
`else
    check("mis.req", {31'd0, bus.o_mem_req}, 32'd1);
    check("mis.addr", bus.o_mem_addr, 32'h0000_1000);
    bus.i_mem_gnt    = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h1234_5678;
    tick();
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    check("mis.done", {31'd0, bus.o_done}, 32'd1);
    check("mis.fault", {31'd0, bus.o_fault}, 32'd0);
    check("mis.result", bus.o_result, 32'h1234_5678);
`endif

    // Reset during WAIT, then a late response
    drive_req(32'h0000_4000, 32'h0, 1'b0, 2'd2, 1'b0, 5'd11);
    tick();
    bus.i_valid   = 1'b0;
    bus.i_mem_gnt = 1'b1;
    tick();
    bus.i_mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_outputs_check("rst_wait");
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hCAFE_F00D;
    tick();
    bus.i_mem_rvalid = 1'b0;
    reset_outputs_check("late_rvalid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit sitting directly downstream of the address unit. It accepts one computed effective address per request, together with store data, access size and signedness. It runs a single-outstanding request on a valid/grant/response data-memory port, steers byte lanes for stores, and aligns and extends load data. It returns a registered result with destination tag to writeback.

## Interface
- WIDTH, 32, datapath width; only 32 is supported (four byte lanes)
- i_clk  in  1  clock; one clock, reset is synchronous and active-high
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  1  request valid; driven from the address unit's o_valid
- o_ready  out  1  high exactly when the FSM is in IDLE
- i_addr  in  WIDTH  effective byte address
- i_wdata  in  WIDTH  store data, right-justified
- i_store  in  1  1 = store, 0 = load
- i_size  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
- i_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- i_rd  in  5  destination register tag, echoed on completion
- o_mem_req  out  1  bus request
- o_mem_we  out  1  write enable
- o_mem_addr  out  WIDTH  word-aligned address, {addr[31:2], 2'b00}
- o_mem_wdata  out  WIDTH  lane-replicated store data
- o_mem_wstrb  out  4  byte strobes; 0 for loads
- i_mem_gnt  in  1  request accepted
- i_mem_rvalid  in  1  response or acknowledge (loads and stores)
- i_mem_rdata  in  WIDTH  load data
- o_done  out  1  one-cycle completion pulse
- o_result  out  WIDTH  aligned/extended load data; 0 for stores and faults
- o_rd  out  5  captured i_rd
- o_fault  out  1  misaligned access, qualified by o_done

## Operation
- Request is accepted on i_valid & o_ready. Accepted fields are captured into holding registers. i_valid while not ready is ignored; upstream must hold or replay the request.
- FSM states:
  - IDLE: on accept, go to REQ, or to FAULT if misaligned and the check is compiled in.
  - REQ: o_mem_req=1, with all o_mem_* stable until grant. On i_mem_gnt, go to WAIT. If i_mem_rvalid arrives in the same cycle as the grant, complete directly.
  - WAIT: o_mem_req=0. On i_mem_rvalid, complete.
  - FAULT: one cycle, then IDLE.
- Completion: register o_done=1, o_result, o_rd and o_fault, then return to IDLE. All outputs hold until the next completion except o_done.
- Store lanes:
  - byte: strobe 4'b0001<<addr[1:0], wdata {4{d[7:0]}}
  - half: strobe 4'b0011<<{addr[1],1'b0}, wdata {2{d[15:0]}}
  - word: strobe 4'b1111
- Load extract: shift i_mem_rdata right by 8*addr[1:0] (half uses addr[1] only), then extend from 8/16 bits per i_unsigned. Words pass through unchanged.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- i_mem_rvalid in IDLE or REQ (without grant) is ignored.

## Timing
- Reset values: state IDLE, o_ready=1, o_mem_req=0, o_mem_we=0, o_mem_wstrb=0, o_done=0, o_result=0, o_rd=0, o_fault=0. o_mem_addr and o_mem_wdata are 0.
- Cycle timeline: accept at cycle 0; o_mem_req high at cycle 1. With grant at cycle g≥1 and response at cycle r≥g, o_done and o_ready are high at cycle r+1. The minimum is accept→o_done in 2 cycles, with gnt and rvalid both arriving in cycle 1.
- Back-to-back: a new request is accepted in the same cycle o_done is high.
- Fault path: o_done=1 and o_fault=1 at cycle 1, and the bus is never requested.
- Reset mid-operation: the next edge forces IDLE and drops o_mem_req. Late responses are ignored.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misaligned requests take the FAULT path and o_fault is reported.
- LSU_MISALIGN_CHECK_EN undefined: no FAULT state and o_fault is tied to 0. Misaligned low address bits are ignored: half uses lane addr[1], word uses lane 0. Such accesses are issued normally.

## Structure
- Package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - the FSM state enum
  - the lane count constant
- Sub-module lsu_align: purely combinational store strobe/replication and load shift/extend, instantiated once. The FSM and registers stay in load_store_unit.

## Test plan
- Word load, addr 0x1000, gnt at cycle 1, rvalid at cycle 3, rdata 0xDEADBEEF -> o_mem_addr 0x1000, o_done at cycle 4, o_result 0xDEADBEEF, o_rd echoed.
- Signed byte load, addr 0x1003, rdata 0x80FFFFFF -> o_result 0xFFFFFF80; with i_unsigned=1 -> 0x00000080.
- Half store, addr 0x2002, wdata 0x0000ABCD -> o_mem_wstrb 4'b1100, o_mem_wdata 0xABCDABCD, o_mem_we=1, o_result 0.
- Grant held low for 5 cycles -> o_mem_req and all o_mem_* stable throughout; a stray rvalid during REQ is ignored.
- Word load at 0x1002 -> with LSU_MISALIGN_CHECK_EN: o_fault=1 and o_done at cycle 1, o_mem_req never high; without it: access at 0x1000, o_fault=0.
- i_rst pulsed during WAIT, then rvalid -> o_ready=1, o_done stays 0, all outputs at reset values.
